// File: rtl/bp_me_cce_pending_table_if.sv
// Bus bundle for the CCE pending-transaction counter table: status, write
// channel (request and applied-write stream) and read channel.
interface bp_me_cce_pending_table_if #(
    parameter int num_way_groups_p = 64,
    parameter int width_p          = 3,
    localparam int lg_num_way_groups_lp = (num_way_groups_p == 1) ? 1 : $clog2(num_way_groups_p),
    localparam int cnt_width_lp         = (num_way_groups_p + 1 == 1) ? 1 : $clog2(num_way_groups_p + 1)
);
    logic                            ready_o;

    logic                            w_v_i;
    logic [lg_num_way_groups_lp-1:0] w_wg_i;
    logic [1:0]                      w_op_i;
    logic                            w_v_o;
    logic [lg_num_way_groups_lp-1:0] w_wg_o;
    logic [width_p-1:0]              w_val_o;

    logic                            r_v_i;
    logic [lg_num_way_groups_lp-1:0] r_wg_i;
    logic                            r_v_o;
    logic [width_p-1:0]              r_count_o;
    logic                            r_pending_o;

    logic [cnt_width_lp-1:0]         nonzero_cnt_o;
    logic                            err_o;

    modport master (
        input  ready_o,
        output w_v_i, w_wg_i, w_op_i,
        input  w_v_o, w_wg_o, w_val_o,
        output r_v_i, r_wg_i,
        input  r_v_o, r_count_o, r_pending_o,
        input  nonzero_cnt_o, err_o
    );

    modport slave (
        output ready_o,
        input  w_v_i, w_wg_i, w_op_i,
        output w_v_o, w_wg_o, w_val_o,
        input  r_v_i, r_wg_i,
        output r_v_o, r_count_o, r_pending_o,
        output nonzero_cnt_o, err_o
    );
endinterface

// File: rtl/bp_me_cce_pending_table.sv
// Per-way-group pending-transaction counter table for the CCE: saturating
// inc/dec/clear writes, write-first registered reads, non-zero entry count.
module bp_me_cce_pending_table #(
    parameter int num_way_groups_p = 64,
    parameter int width_p          = 3
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bp_me_cce_pending_table_if.slave io
);
    localparam int lg_num_way_groups_lp = (num_way_groups_p == 1) ? 1 : $clog2(num_way_groups_p);
    localparam int cnt_width_lp         = (num_way_groups_p + 1 == 1) ? 1 : $clog2(num_way_groups_p + 1);

    localparam logic [0:0] state_init_lp  = 1'b0;
    localparam logic [0:0] state_ready_lp = 1'b1;

    localparam logic [1:0] op_inc_lp   = 2'd0;
    localparam logic [1:0] op_dec_lp   = 2'd1;
    localparam logic [1:0] op_clear_lp = 2'd2;
    localparam logic [1:0] op_nop_lp   = 2'd3;

    localparam logic [width_p-1:0]              max_val_lp  = '1;
    localparam logic [lg_num_way_groups_lp-1:0] last_idx_lp = lg_num_way_groups_lp'(num_way_groups_p - 1);

    logic [0:0]                      state_r;
    logic [lg_num_way_groups_lp-1:0] init_idx_r;
    logic [width_p-1:0]              mem_r [num_way_groups_p];

    logic                            ready;
    logic                            w_apply;
    logic [width_p-1:0]              w_cur;
    logic [width_p-1:0]              w_new;
    logic                            w_err;
    logic                            r_fire;
    logic [width_p-1:0]              r_val;
    logic                            nz_inc;
    logic                            nz_dec;

    logic                            w_v_r;
    logic [lg_num_way_groups_lp-1:0] w_wg_r;
    logic [width_p-1:0]              w_val_r;
    logic                            r_v_r;
    logic [width_p-1:0]              r_count_r;
    logic                            r_pending_r;
    logic [cnt_width_lp-1:0]         nonzero_cnt_r;
    logic                            err_r;

    assign ready   = (state_r == state_ready_lp);
    assign w_apply = io.w_v_i & ready & (io.w_op_i != op_nop_lp);
    assign r_fire  = io.r_v_i & ready;

    always_comb begin
        w_cur = mem_r[io.w_wg_i];
        w_new = w_cur;
        w_err = 1'b0;
        case (io.w_op_i)
            op_inc_lp: begin
                if (w_cur == max_val_lp) w_err = 1'b1;
                else                     w_new = w_cur + 1'b1;
            end
            op_dec_lp: begin
                if (w_cur == '0) w_err = 1'b1;
                else             w_new = w_cur - 1'b1;
            end
            op_clear_lp: w_new = '0;
            default: w_new = w_cur;
        endcase
    end

    // Write-first: a read colliding with an applied write sees the new value
    always_comb begin
        if (w_apply && (io.w_wg_i == io.r_wg_i)) r_val = w_new;
        else                                     r_val = mem_r[io.r_wg_i];
    end

    assign nz_inc = w_apply & (w_cur == '0) & (w_new != '0);
    assign nz_dec = w_apply & (w_cur != '0) & (w_new == '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= state_init_lp;
            init_idx_r <= '0;
        end else if (state_r == state_init_lp) begin
            init_idx_r <= init_idx_r + 1'b1;
            if (init_idx_r == last_idx_lp) state_r <= state_ready_lp;
        end
    end

    // Storage has no reset; INIT sweeps every entry to zero before ready rises
    always_ff @(posedge clk_i) begin
        if (!ready)       mem_r[init_idx_r] <= '0;
        else if (w_apply) mem_r[io.w_wg_i]  <= w_new;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_v_r         <= 1'b0;
            w_wg_r        <= '0;
            w_val_r       <= '0;
            r_v_r         <= 1'b0;
            r_count_r     <= '0;
            r_pending_r   <= 1'b0;
            nonzero_cnt_r <= '0;
            err_r         <= 1'b0;
        end else begin
            w_v_r <= w_apply;
            if (w_apply) begin
                w_wg_r  <= io.w_wg_i;
                w_val_r <= w_new;
            end
            r_v_r <= r_fire;
            if (r_fire) begin
                r_count_r   <= r_val;
                r_pending_r <= (r_val != '0);
            end
            if (nz_inc)      nonzero_cnt_r <= nonzero_cnt_r + 1'b1;
            else if (nz_dec) nonzero_cnt_r <= nonzero_cnt_r - 1'b1;
            if (w_apply & w_err) err_r <= 1'b1;
        end
    end

    assign io.ready_o       = ready;
    assign io.w_v_o         = w_v_r;
    assign io.w_wg_o        = w_wg_r;
    assign io.w_val_o       = w_val_r;
    assign io.r_v_o         = r_v_r;
    assign io.r_count_o     = r_count_r;
    assign io.r_pending_o   = r_pending_r;
    assign io.nonzero_cnt_o = nonzero_cnt_r;
    assign io.err_o         = err_r;
endmodule

// File: tb/tb_bp_me_cce_pending_table.sv
// Scoreboard bench for bp_me_cce_pending_table: stimulus pushes expected
// write/read responses, a negedge monitor pops and compares them.
module tb_bp_me_cce_pending_table;
    localparam int N  = 64;
    localparam int W  = 3;
    localparam int LG = 6;

    typedef struct {
        int         due;
        logic [5:0] wg;
        logic [2:0] val;
    } wexp_t;

    typedef struct {
        int         due;
        logic [2:0] val;
    } rexp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bp_me_cce_pending_table_if #(.num_way_groups_p(N), .width_p(W)) io ();

    bp_me_cce_pending_table #(.num_way_groups_p(N), .width_p(W)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .io        (io)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    wexp_t wq[$];
    rexp_t rq[$];

    logic [2:0] model [N];
    int         nz_m;
    bit         err_m;
    bit         bench_ready;
    logic [2:0] hold_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) model[i] = '0;
        nz_m     = 0;
        err_m    = 1'b0;
        hold_cnt = '0;
    endfunction

    // Drive one cycle of inputs, record expectations, then advance past the edge
    task automatic drive(input bit wv, input int wg, input int op, input bit rv, input int rwg);
        logic [2:0] cur;
        logic [2:0] nv;
        io.w_v_i  = wv;
        io.w_wg_i = LG'(wg);
        io.w_op_i = 2'(op);
        io.r_v_i  = rv;
        io.r_wg_i = LG'(rwg);
        if (bench_ready) begin
            if (wv && op != 3) begin
                cur = model[wg];
                nv  = cur;
                if (op == 0) begin
                    if (cur == 3'd7) err_m = 1'b1; else nv = cur + 3'd1;
                end else if (op == 1) begin
                    if (cur == 3'd0) err_m = 1'b1; else nv = cur - 3'd1;
                end else begin
                    nv = 3'd0;
                end
                if (cur == 0 && nv != 0) nz_m++;
                if (cur != 0 && nv == 0) nz_m--;
                model[wg] = nv;
                wq.push_back('{due: cyc + 1, wg: LG'(wg), val: nv});
            end
            if (rv) rq.push_back('{due: cyc + 1, val: model[rwg]});
        end
        @(posedge clk);
        #2;
        if (bench_ready) begin
            check("nonzero_cnt_o", 32'(io.nonzero_cnt_o), 32'(nz_m));
            check("err_o", io.err_o, err_m);
        end
    endtask

    task automatic idle();
        drive(1'b0, 0, 3, 1'b0, 0);
    endtask

    // Walk through INIT with ops offered every cycle; they must be dropped
    task automatic init_wait();
        for (int i = 1; i <= N; i++) begin
            drive(1'b1, i % N, i % 3, 1'b1, i % N);
            check("ready_o_init", io.ready_o, (i == N));
        end
        bench_ready = 1'b1;
        check("err_o_after_init", io.err_o, 1'b0);
        check("nonzero_after_init", 32'(io.nonzero_cnt_o), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready_o", io.ready_o, 1'b0);
        check("rst_w_v_o", io.w_v_o, 1'b0);
        check("rst_w_wg_o", 32'(io.w_wg_o), 0);
        check("rst_w_val_o", 32'(io.w_val_o), 0);
        check("rst_r_v_o", io.r_v_o, 1'b0);
        check("rst_r_count_o", 32'(io.r_count_o), 0);
        check("rst_r_pending_o", io.r_pending_o, 1'b0);
        check("rst_nonzero_cnt_o", 32'(io.nonzero_cnt_o), 0);
        check("rst_err_o", io.err_o, 1'b0);
    endtask

    task automatic apply_reset();
        reset_n     = 1'b0;
        bench_ready = 1'b0;
        model_clear();
        #1;
        check_reset_outputs();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    // Monitor: every cycle the DUT valids must match whether an expectation is due
    initial begin
        wexp_t we;
        rexp_t re;
        bit    wdue;
        bit    rdue;
        forever begin
            @(negedge clk);
            wdue = (wq.size() > 0) && (wq[0].due == cyc);
            rdue = (rq.size() > 0) && (rq[0].due == cyc);
            check("w_v_o", io.w_v_o, wdue);
            if (wdue) begin
                we = wq.pop_front();
                if (io.w_v_o) begin
                    check("w_wg_o", 32'(io.w_wg_o), 32'(we.wg));
                    check("w_val_o", 32'(io.w_val_o), 32'(we.val));
                end
            end
            check("r_v_o", io.r_v_o, rdue);
            if (rdue) begin
                re = rq.pop_front();
                hold_cnt = re.val;
                if (io.r_v_o) begin
                    check("r_count_o", 32'(io.r_count_o), 32'(re.val));
                    check("r_pending_o", io.r_pending_o, (re.val != 3'd0));
                end
            end else if (reset_n) begin
                check("r_count_hold", 32'(io.r_count_o), 32'(hold_cnt));
            end
        end
    end

    initial begin
        io.w_v_i  = 1'b0;
        io.w_wg_i = '0;
        io.w_op_i = 2'd3;
        io.r_v_i  = 1'b0;
        io.r_wg_i = '0;
        bench_ready = 1'b0;
        model_clear();

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs();
        reset_n = 1'b1;
        init_wait();

        // inc wg5 three times, then read it back
        for (int k = 0; k < 3; k++) drive(1'b1, 5, 0, 1'b0, 0);
        drive(1'b0, 0, 3, 1'b1, 5);
        check("t2_r_count_o", 32'(io.r_count_o), 3);
        check("t2_r_pending_o", io.r_pending_o, 1'b1);
        check("t2_nonzero", 32'(io.nonzero_cnt_o), 1);

        // write-first collision: read and dec of wg7 in the same cycle
        drive(1'b1, 7, 0, 1'b0, 0);
        check("t4_nonzero_before", 32'(io.nonzero_cnt_o), 2);
        drive(1'b1, 7, 1, 1'b1, 7);
        check("t4_r_count_o", 32'(io.r_count_o), 0);
        check("t4_r_pending_o", io.r_pending_o, 1'b0);
        check("t4_nonzero_after", 32'(io.nonzero_cnt_o), 1);

        // every entry non-zero, then clear wg63 twice
        for (int g = 0; g < N; g++) drive(1'b1, g, 0, 1'b0, 0);
        check("t5_nonzero_full", 32'(io.nonzero_cnt_o), 64);
        drive(1'b1, 63, 2, 1'b0, 0);
        check("t5_nonzero_clear", 32'(io.nonzero_cnt_o), 63);
        drive(1'b1, 63, 2, 1'b0, 0);
        check("t5_nonzero_clear2", 32'(io.nonzero_cnt_o), 63);
        check("t5_err_o", io.err_o, 1'b0);
        idle();

        // reset mid-READY with counts set, then abort one INIT partway
        apply_reset();
        for (int i = 0; i < 20; i++) drive(1'b1, 3, 0, 1'b1, 3);
        check("t6_ready_mid_init", io.ready_o, 1'b0);
        apply_reset();
        init_wait();
        for (int g = 0; g < N; g++) drive(1'b0, 0, 3, 1'b1, g);
        idle();
        check("t6_nonzero", 32'(io.nonzero_cnt_o), 0);

        // saturation at max and underflow at zero
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 9, 0, 1'b0, 0);
            if (k == 7) check("t3_err_before", io.err_o, 1'b0);
        end
        check("t3_err_after", io.err_o, 1'b1);
        drive(1'b0, 0, 3, 1'b1, 9);
        check("t3_r_count_sat", 32'(io.r_count_o), 7);
        drive(1'b1, 2, 1, 1'b0, 0);
        check("t3_err_sticky", io.err_o, 1'b1);
        drive(1'b0, 0, 3, 1'b1, 2);
        check("t3_r_count_under", 32'(io.r_count_o), 0);
        check("t3_nonzero", 32'(io.nonzero_cnt_o), 1);
        idle();
        idle();

        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
